nfc_multichip_ctrl: RTL and testbench

NFC_MULTICHIP_CTRL -- requirements
Module: nfc_multichip_ctrl

---
 rtl/nfc_pkg.sv | 43 ++++
 rtl/nfc_page_buffer.sv | 48 ++++
 rtl/nfc_multichip_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_nfc_multichip_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_pkg.sv
// Shared definitions for the multi-die NAND flash controller: host command
// encodings, ONFI-style opcodes and the sequencer state enum.
package nfc_pkg;

    localparam logic [2:0] CMD_ERASE   = 3'd0;
    localparam logic [2:0] CMD_PROGRAM = 3'd1;
    localparam logic [2:0] CMD_READ    = 3'd2;

    localparam logic [7:0] OP_READ1  = 8'h00;
    localparam logic [7:0] OP_READ2  = 8'h30;
    localparam logic [7:0] OP_PROG1  = 8'h80;
    localparam logic [7:0] OP_PROG2  = 8'h10;
    localparam logic [7:0] OP_ERASE1 = 8'h60;
    localparam logic [7:0] OP_ERASE2 = 8'hD0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_ADDR,
        S_WDATA,
        S_CMD2,
        S_WAIT_RDY,
        S_RDATA,
        S_DONE
    } state_t;

    function automatic logic [7:0] opcode1(input logic [2:0] cmd);
        case (cmd)
            CMD_PROGRAM: return OP_PROG1;
            CMD_READ:    return OP_READ1;
            default:     return OP_ERASE1;
        endcase
    endfunction

    function automatic logic [7:0] opcode2(input logic [2:0] cmd);
        case (cmd)
            CMD_PROGRAM: return OP_PROG2;
            CMD_READ:    return OP_READ2;
            default:     return OP_ERASE2;
        endcase
    endfunction

endpackage

// File: rtl/nfc_page_buffer.sv
// One-page staging buffer with a host port and a flash port; the controller
// guarantees the two ports are never used in the same cycle.
module nfc_page_buffer #(
    parameter int DIOWidth = 16,
    parameter int PageSize = 2048,
    parameter int PtrWidth = 11
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                i_h_we,
    input  logic                i_h_re,
    input  logic [PtrWidth-1:0] i_h_addr,
    input  logic [DIOWidth-1:0] i_h_wdata,
    output logic [DIOWidth-1:0] o_h_rdata,
    input  logic                i_f_we,
    input  logic                i_f_re,
    input  logic [PtrWidth-1:0] i_f_addr,
    input  logic [DIOWidth-1:0] i_f_wdata,
    output logic [DIOWidth-1:0] o_f_rdata
);

    logic [DIOWidth-1:0] r_mem [PageSize];
    logic [DIOWidth-1:0] r_h_rdata;
    logic [DIOWidth-1:0] r_f_rdata;

    // Storage itself is not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_h_we) begin
            r_mem[i_h_addr] <= i_h_wdata;
        end else if (i_f_we) begin
            r_mem[i_f_addr] <= i_f_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_h_rdata <= '0;
            r_f_rdata <= '0;
        end else begin
            if (i_h_re) r_h_rdata <= r_mem[i_h_addr];
            if (i_f_re) r_f_rdata <= r_mem[i_f_addr];
        end
    end

    assign o_h_rdata = r_h_rdata;
    assign o_f_rdata = r_f_rdata;

endmodule

// File: rtl/nfc_multichip_ctrl.sv
// NAND flash controller for several dies on a shared bus: sequences erase,
// page program and page read, and stages page data in a local buffer.
module nfc_multichip_ctrl
    import nfc_pkg::*;
#(
    parameter int NumChips      = 2,
    parameter int DIOWidth      = 16,
    parameter int PageSize      = 2048,
    parameter int AddressWidth  = 16,
    parameter int TimeoutCycles = 4096,
    localparam int CsWidth      = (NumChips > 1) ? $clog2(NumChips) : 1
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    nfc_start,
    input  logic [2:0]              nfc_cmd,
    input  logic [AddressWidth-1:0] RWA,
    input  logic [CsWidth-1:0]      chip_sel,
    output logic                    nfc_done,
    output logic                    command_error,
    input  logic                    buf_sel,
    input  logic                    buf_we,
    input  logic                    buf_re,
    input  logic [DIOWidth-1:0]     buf_in,
    output logic [DIOWidth-1:0]     buf_out,
    output logic [DIOWidth-1:0]     dio_out,
    output logic                    dio_oe,
    input  logic [DIOWidth-1:0]     dio_in,
    output logic                    CLE,
    output logic                    ALE,
    output logic                    wEn,
    output logic                    rEn,
    output logic [NumChips-1:0]     cEn,
    input  logic [NumChips-1:0]     status,
    output state_t                  o_dbg_state
);

    localparam int AddrBytes = (AddressWidth + 7) / 8;
    localparam int AddrPad   = AddrBytes * 8;
    localparam int PtrWidth  = (PageSize > 1) ? $clog2(PageSize) : 1;
    localparam int CntMax    = (PageSize > TimeoutCycles) ? PageSize : TimeoutCycles;
    localparam int CntWidth  = $clog2(CntMax + 1);

    state_t              r_state;
    logic [2:0]          r_cmd;
    logic [CsWidth-1:0]  r_chip;
    logic [AddrPad-1:0]  r_rwa;
    logic [CntWidth-1:0] r_cnt;
    logic                r_cle, r_ale, r_wen, r_ren, r_oe, r_done, r_err;
    logic [NumChips-1:0] r_cen;
    logic [DIOWidth-1:0] r_dio_out;
    logic [PtrWidth-1:0] r_hptr;

    logic                w_idle, w_cmd_ok, w_chip_ok, w_last_addr, w_last_word;
    logic [NumChips-1:0] w_onehot;
    logic                w_h_we, w_h_re, w_f_we, w_f_re;
    logic [PtrWidth-1:0] w_f_addr;
    logic [DIOWidth-1:0] w_f_rdata;

    assign w_idle      = (r_state == S_IDLE);
    assign w_cmd_ok    = (nfc_cmd == CMD_ERASE) || (nfc_cmd == CMD_PROGRAM) || (nfc_cmd == CMD_READ);
    assign w_chip_ok   = (int'(chip_sel) < NumChips);
    assign w_last_addr = (r_cnt == CntWidth'(AddrBytes - 1));
    assign w_last_word = (r_cnt == CntWidth'(PageSize - 1));

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NumChips; i++) begin
            if (int'(chip_sel) == i) w_onehot[i] = 1'b1;
        end
    end

    assign w_h_we = w_idle && buf_sel && buf_we;
    assign w_h_re = w_idle && buf_sel && buf_re && !buf_we;
    assign w_f_we = (r_state == S_RDATA);
    // Program data is fetched one word ahead so it is on the bus during its own cycle.
    assign w_f_re = ((r_state == S_ADDR) && w_last_addr && (r_cmd == CMD_PROGRAM)) ||
                    ((r_state == S_WDATA) && !w_last_word);

    always_comb begin
        w_f_addr = '0;
        if (r_state == S_WDATA) begin
            w_f_addr = r_cnt[PtrWidth-1:0] + PtrWidth'(1);
        end else if (r_state == S_RDATA) begin
            w_f_addr = r_cnt[PtrWidth-1:0];
        end
    end

    nfc_page_buffer #(
        .DIOWidth (DIOWidth),
        .PageSize (PageSize),
        .PtrWidth (PtrWidth)
    ) u_buf (
        .clk       (clk),
        .Reset     (Reset),
        .i_h_we    (w_h_we),
        .i_h_re    (w_h_re),
        .i_h_addr  (r_hptr),
        .i_h_wdata (buf_in),
        .o_h_rdata (buf_out),
        .i_f_we    (w_f_we),
        .i_f_re    (w_f_re),
        .i_f_addr  (w_f_addr),
        .i_f_wdata (dio_in),
        .o_f_rdata (w_f_rdata)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_hptr <= '0;
        end else if (w_idle) begin
            if (!buf_sel) begin
                r_hptr <= '0;
            end else if (buf_we || buf_re) begin
                r_hptr <= (r_hptr == PtrWidth'(PageSize - 1)) ? '0 : r_hptr + PtrWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_chip    <= '0;
            r_rwa     <= '0;
            r_cnt     <= '0;
            r_cle     <= 1'b0;
            r_ale     <= 1'b0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_oe      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cen     <= '0;
            r_dio_out <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (nfc_start && !w_idle) r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (nfc_start) begin
                        if (!w_cmd_ok || !w_chip_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cmd     <= nfc_cmd;
                            r_chip    <= chip_sel;
                            r_rwa     <= AddrPad'(RWA);
                            r_cen     <= w_onehot;
                            r_cle     <= 1'b1;
                            r_oe      <= 1'b1;
                            r_dio_out <= DIOWidth'(opcode1(nfc_cmd));
                            r_state   <= S_CMD1;
                        end
                    end
                end
                S_CMD1: begin
                    r_cle     <= 1'b0;
                    r_ale     <= 1'b1;
                    r_dio_out <= DIOWidth'(r_rwa[7:0]);
                    r_rwa     <= r_rwa >> 8;
                    r_cnt     <= '0;
                    r_state   <= S_ADDR;
                end
                S_ADDR: begin
                    if (!w_last_addr) begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_dio_out <= DIOWidth'(r_rwa[7:0]);
                        r_rwa     <= r_rwa >> 8;
                    end else begin
                        r_ale <= 1'b0;
                        r_cnt <= '0;
                        if (r_cmd == CMD_PROGRAM) begin
                            r_wen   <= 1'b1;
                            r_state <= S_WDATA;
                        end else begin
                            r_cle     <= 1'b1;
                            r_dio_out <= DIOWidth'(opcode2(r_cmd));
                            r_state   <= S_CMD2;
                        end
                    end
                end
                S_WDATA: begin
                    if (!w_last_word) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_wen     <= 1'b0;
                        r_cnt     <= '0;
                        r_cle     <= 1'b1;
                        r_dio_out <= DIOWidth'(opcode2(r_cmd));
                        r_state   <= S_CMD2;
                    end
                end
                S_CMD2: begin
                    r_cle     <= 1'b0;
                    r_oe      <= 1'b0;
                    r_dio_out <= '0;
                    r_cnt     <= '0;
                    r_state   <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (status[r_chip]) begin
                        r_cnt <= '0;
                        if (r_cmd == CMD_READ) begin
                            r_ren   <= 1'b1;
                            r_state <= S_RDATA;
                        end else begin
                            r_cen   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (r_cnt == CntWidth'(TimeoutCycles - 1)) begin
                        // A die that never reports ready ends the operation with an error.
                        r_cnt   <= '0;
                        r_cen   <= '0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RDATA: begin
                    if (!w_last_word) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_ren   <= 1'b0;
                        r_cen   <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // During WDATA the bus carries the buffer's registered read data directly.
    assign dio_out       = (r_state == S_WDATA) ? w_f_rdata : r_dio_out;
    assign dio_oe        = r_oe;
    assign CLE           = r_cle;
    assign ALE           = r_ale;
    assign wEn           = r_wen;
    assign rEn           = r_ren;
    assign cEn           = r_cen;
    assign nfc_done      = r_done;
    assign command_error = r_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_nfc_multichip_ctrl.sv
// Self-checking bench: expected flash bus traces and buffer contents come from
// a page-level model built from the command rules, compared cycle by cycle.
module tb_nfc_multichip_ctrl;
    import nfc_pkg::*;

    localparam int NC = 2;
    localparam int DW = 16;
    localparam int PS = 2048;
    localparam int AW = 16;
    localparam int TO = 4096;
    localparam int CSW = 1;
    localparam int ABYTES = (AW + 7) / 8;
    localparam int TW = 5 + NC + DW;
    localparam int OP_BUDGET = PS + TO + 200;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          nfc_start = 1'b0;
    logic [2:0]    nfc_cmd = '0;
    logic [AW-1:0] RWA = '0;
    logic [CSW-1:0] chip_sel = '0;
    logic          nfc_done, command_error;
    logic          buf_sel = 1'b0, buf_we = 1'b0, buf_re = 1'b0;
    logic [DW-1:0] buf_in = '0;
    logic [DW-1:0] buf_out, dio_out;
    logic          dio_oe;
    logic [DW-1:0] dio_in = '0;
    logic          CLE, ALE, wEn, rEn;
    logic [NC-1:0] cEn;
    logic [NC-1:0] status = '0;
    state_t        dut_state;

    nfc_multichip_ctrl #(
        .NumChips(NC), .DIOWidth(DW), .PageSize(PS), .AddressWidth(AW), .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .Reset(Reset), .nfc_start(nfc_start), .nfc_cmd(nfc_cmd), .RWA(RWA),
        .chip_sel(chip_sel), .nfc_done(nfc_done), .command_error(command_error),
        .buf_sel(buf_sel), .buf_we(buf_we), .buf_re(buf_re), .buf_in(buf_in), .buf_out(buf_out),
        .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in), .CLE(CLE), .ALE(ALE),
        .wEn(wEn), .rEn(rEn), .cEn(cEn), .status(status), .o_dbg_state(dut_state)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] ref_buf [PS];
    logic [DW-1:0] die_data [PS];
    logic [TW-1:0] exp_q [$];
    logic [7:0]    op1_tab [3] = '{8'h60, 8'h80, 8'h00};
    logic [7:0]    op2_tab [3] = '{8'hD0, 8'h10, 8'h30};

    int  n_checks = 0;
    int  n_fail = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    bit  mon_en = 1'b1;
    logic [TW-1:0] mon_exp;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] tw(input bit cle, input bit ale, input bit wen, input bit ren,
                                         input bit oe, input logic [NC-1:0] cen, input logic [DW-1:0] d);
        logic [DW-1:0] dm;
        dm = oe ? d : '0;
        return {cle, ale, wen, ren, oe, cen, dm};
    endfunction

    // Expected sequence of strobed bus cycles for one operation.
    function automatic void build_trace(input int cmd, input int rwa, input int chip, input bit timeout);
        logic [NC-1:0] cen;
        cen = '0;
        cen[chip] = 1'b1;
        exp_q.delete();
        exp_q.push_back(tw(1, 0, 0, 0, 1, cen, DW'(op1_tab[cmd])));
        for (int b = 0; b < ABYTES; b++) exp_q.push_back(tw(0, 1, 0, 0, 1, cen, DW'((rwa >> (8 * b)) & 8'hFF)));
        if (cmd == 1) for (int i = 0; i < PS; i++) exp_q.push_back(tw(0, 0, 1, 0, 1, cen, ref_buf[i]));
        exp_q.push_back(tw(1, 0, 0, 0, 1, cen, DW'(op2_tab[cmd])));
        if (cmd == 2 && !timeout) for (int i = 0; i < PS; i++) exp_q.push_back(tw(0, 0, 0, 1, 0, cen, '0));
    endfunction

    always @(negedge clk) begin
        if (!Reset) begin
            if (nfc_done) done_cnt++;
            if (command_error) err_cnt++;
            if (mon_en && (CLE || ALE || wEn || rEn)) begin
                mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                chk("bus", tw(CLE, ALE, wEn, rEn, dio_oe, cEn, dio_out), mon_exp);
            end
        end
    end

    task automatic chk_outputs_zero();
        chk("z_done", nfc_done, 0);
        chk("z_err", command_error, 0);
        chk("z_cle", CLE, 0);
        chk("z_ale", ALE, 0);
        chk("z_wen", wEn, 0);
        chk("z_ren", rEn, 0);
        chk("z_cen", cEn, 0);
        chk("z_oe", dio_oe, 0);
        chk("z_dio", dio_out, 0);
        chk("z_bufout", buf_out, 0);
        chk("z_state", dut_state, S_IDLE);
    endtask

    task automatic host_fill(input int mode);
        for (int i = 0; i < PS; i++) begin
            @(negedge clk);
            buf_sel = 1'b1;
            buf_we = 1'b1;
            buf_re = 1'($urandom_range(0, 1));
            buf_in = (mode != 0) ? DW'($urandom) : DW'(i);
            ref_buf[i] = buf_in;
        end
        @(negedge clk);
        buf_sel = 1'b0; buf_we = 1'b0; buf_re = 1'b0;
    endtask

    task automatic host_read(input int n);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) chk("buf_out", buf_out, ref_buf[(i - 1) % PS]);
            if (i < n) begin
                buf_sel = 1'b1; buf_re = 1'b1; buf_we = 1'b0;
            end else begin
                buf_sel = 1'b0; buf_re = 1'b0;
            end
        end
        @(negedge clk);
        chk("buf_hold", buf_out, ref_buf[(n - 1) % PS]);
    endtask

    task automatic bad_cmd(input int cmd);
        int e0, d0;
        e0 = err_cnt; d0 = done_cnt;
        @(negedge clk);
        nfc_start = 1'b1; nfc_cmd = 3'(cmd); chip_sel = '0;
        @(negedge clk);
        nfc_start = 1'b0;
        chk("bad_err", command_error, 1);
        chk("bad_state", dut_state, S_IDLE);
        @(negedge clk);
        chk("bad_err_pulse", command_error, 0);
        repeat (3) @(negedge clk);
        chk("bad_no_done", done_cnt - d0, 0);
        chk("bad_err_cnt", err_cnt - e0, 1);
    endtask

    // rdy_delay < 0 means the die never reports ready.
    task automatic run_op(input int cmd, input int rwa, input int chip, input int rdy_delay,
                          input int inject_at, input bit other_pulse, input int reset_at);
        int cyc, widx, ridx, since, e0, d0, exp_errs;
        bit in_wait, got_lat, done_seen, timeout, exp_err_next, aborted;
        logic [DW-1:0] bufout0;
        timeout = (rdy_delay < 0);
        build_trace(cmd, rwa, chip, timeout);
        e0 = err_cnt; d0 = done_cnt; bufout0 = buf_out;
        exp_errs = (inject_at >= 0 ? 1 : 0) + (timeout ? 1 : 0);
        @(negedge clk);
        buf_sel = 1'b0; buf_we = 1'b0; buf_re = 1'b0;
        nfc_start = 1'b1; nfc_cmd = 3'(cmd); RWA = AW'(rwa); chip_sel = CSW'(chip);
        cyc = 0; widx = 0; ridx = 0; since = 0;
        in_wait = 0; got_lat = 0; done_seen = 0; exp_err_next = 0; aborted = 0;
        while (!done_seen && !aborted && cyc < OP_BUDGET) begin
            @(negedge clk);
            cyc++;
            nfc_start = 1'b0;
            status = '0;
            buf_sel = 1'($urandom_range(0, 1));
            buf_we = 1'($urandom_range(0, 1));
            buf_re = 1'($urandom_range(0, 1));
            buf_in = DW'($urandom);
            if (exp_err_next) begin
                chk("err_busy", command_error, 1);
                exp_err_next = 0;
            end
            if (rEn) begin
                dio_in = die_data[ridx % PS];
                ridx++;
            end else begin
                dio_in = DW'($urandom);
            end
            if (wEn) begin
                if (widx == reset_at) begin
                    Reset = 1'b1;
                    mon_en = 1'b0;
                    exp_q.delete();
                    buf_sel = 1'b0; buf_we = 1'b0; buf_re = 1'b0;
                    aborted = 1;
                end else if (widx == inject_at) begin
                    nfc_start = 1'b1;
                    nfc_cmd = 3'($urandom_range(0, 7));
                    exp_err_next = 1;
                end
                widx++;
            end
            if (!aborted) begin
                if (in_wait && !got_lat) begin
                    since++;
                    if (nfc_done || rEn) begin
                        got_lat = 1;
                        chk("rdy_latency", since, timeout ? TO + 1 : rdy_delay + 1);
                    end else begin
                        if (since == 1) chk("cen_wait", cEn, NC'(1) << chip);
                        if (since == rdy_delay) status[chip] = 1'b1;
                        if (other_pulse && since == 1) status[(chip + 1) % NC] = 1'b1;
                    end
                end
                if (!in_wait && CLE && dio_oe && dio_out == DW'(op2_tab[cmd])) begin
                    in_wait = 1;
                    since = 0;
                end
                if (nfc_done) begin
                    done_seen = 1;
                    chk("done_err", command_error, timeout);
                    chk("done_cen", cEn, 0);
                end
            end
        end
        if (aborted) begin
            @(negedge clk);
            chk_outputs_zero();
            Reset = 1'b0;
            mon_en = 1'b1;
            repeat (5) @(negedge clk);
            chk("abort_no_done", done_cnt - d0, 0);
            chk("abort_idle", dut_state, S_IDLE);
        end else begin
            chk("op_done", done_seen, 1);
            @(negedge clk);
            buf_sel = 1'b0; buf_we = 1'b0; buf_re = 1'b0;
            chk("done_pulse", nfc_done, 0);
            chk("post_idle", dut_state, S_IDLE);
            chk("trace_left", exp_q.size(), 0);
            chk("done_count", done_cnt - d0, 1);
            chk("err_count", err_cnt - e0, exp_errs);
            chk("bufout_hold", buf_out, bufout0);
            if (cmd == 2 && !timeout) for (int i = 0; i < PS; i++) ref_buf[i] = die_data[i];
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_outputs_zero();
        Reset = 1'b0;
        repeat (2) @(negedge clk);

        // Program page 0..PS-1 to die 1 at row 0x1234, ready after 10 cycles
        host_fill(0);
        run_op(1, 16'h1234, 1, 10, -1, 1'b0, -1);

        // Read from die 0 returning ~i, then read back through the host port with wrap
        for (int i = 0; i < PS; i++) die_data[i] = DW'(~i);
        run_op(2, int'($urandom_range(0, 16'hFFFF)), 0, int'($urandom_range(1, 30)), -1, 1'b0, -1);
        host_read(PS + 3);

        // Erase with no ready status: timeout
        run_op(0, int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, NC - 1)), -1, -1, 1'b0, -1);

        // Errors: invalid command, start while busy, ready from the wrong die
        bad_cmd(5);
        host_fill(1);
        run_op(1, int'($urandom_range(0, 16'hFFFF)), 1, 20, int'($urandom_range(1, PS - 2)), 1'b1, -1);

        // Reset in the middle of WDATA, then a fresh program
        run_op(1, 16'hBEEF, 0, 5, -1, 1'b0, 100);
        host_fill(1);
        run_op(1, int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, NC - 1)), 7, -1, 1'b0, -1);

        // Randomized operations
        for (int k = 0; k < 4; k++) begin
            int c;
            c = int'($urandom_range(0, 3));
            if (c == 3) begin
                bad_cmd(int'($urandom_range(3, 7)));
            end else begin
                if (c == 1) host_fill(1);
                if (c == 2) for (int i = 0; i < PS; i++) die_data[i] = DW'($urandom);
                run_op(c, int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, NC - 1)),
                       int'($urandom_range(2, 40)), -1, 1'($urandom_range(0, 1)), -1);
                if (c == 2) host_read(8);
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
